// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory request/response bundle
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem handshake, bubble insertion; IFETCH_PERF_CNT_EN adds counters
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               hlt,
    output logic [31:0]        instruction,
    output logic               bubble,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]        pc_out,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
);
`else
    output logic [31:0]        pc_out
);
`endif

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        bubble_q, bubble_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        accept;
    logic        load_bubble;

    // Request drops while reset is held so memory never sees a stale address.
    assign imem.imem_req  = rst_n & (state_q == S_RUN);
    assign imem.imem_addr = pc_q;
    assign instruction    = instr_q;
    assign bubble         = bubble_q;
    assign pc_out         = pc_out_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        bubble_d    = bubble_q;
        pc_out_d    = pc_out_q;
        accept      = 1'b0;
        load_bubble = 1'b0;
        if (state_q == S_RUN) begin
            if (redirect) begin
                pc_d        = redirect_pc;
                instr_d     = NOP_INSTR;
                bubble_d    = 1'b1;
                load_bubble = 1'b1;
            end else if (hlt) begin
                state_d     = S_HALT;
                instr_d     = NOP_INSTR;
                bubble_d    = 1'b1;
                load_bubble = 1'b1;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (imem.imem_ready) begin
                instr_d  = imem.imem_rdata;
                bubble_d = 1'b0;
                pc_out_d = pc_q;
                pc_d     = pc_q + PC_STEP;
                accept   = 1'b1;
            end else begin
                instr_d     = NOP_INSTR;
                bubble_d    = 1'b1;
                load_bubble = 1'b1;
            end
        end else begin
            // Halt re-asserts the bubble every edge; only reset leaves this state.
            load_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            bubble_q <= 1'b1;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            bubble_q <= bubble_d;
            pc_out_q <= pc_out_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (accept)      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_flags;
    assign unused_flags = accept ^ load_bubble;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized bench for instr_fetch against a reference model
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, hlt;
    logic [31:0] redirect_pc;
    logic [31:0] instruction, pc_out;
    logic        bubble;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif

    instr_fetch_if imem_bus ();

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt         (hlt),
        .instruction (instruction),
        .bubble      (bubble),
`ifdef IFETCH_PERF_CNT_EN
        .pc_out      (pc_out),
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`else
        .pc_out      (pc_out)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h00A0_0093;
        return {a[15:0] ^ 16'hC0DE, a[15:0]} | 32'h3;
    endfunction

    always_comb imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc_out, m_fcnt, m_bcnt;
    logic        m_bub, m_halt;
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, ~m_halt});
        check("imem_addr", imem_bus.imem_addr, m_pc);
        check("instruction", instruction, m_instr);
        check("bubble", {31'd0, bubble}, {31'd0, m_bub});
        check("pc_out", pc_out, m_pc_out);
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, m_fcnt);
        check("bubble_cnt", bubble_cnt, m_bcnt);
`endif
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_bub = 1'b1; m_pc_out = 32'h0;
        m_halt = 1'b0; m_fcnt = 32'd0; m_bcnt = 32'd0;
    endtask

    task automatic do_reset();
        stall = 0; redirect = 0; hlt = 0; redirect_pc = 0;
        imem_bus.imem_ready = 0;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
        check_all_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
    endtask

    task automatic check_all_reset();
        check("rst_addr", imem_bus.imem_addr, 32'h0);
        check("rst_instr", instruction, NOP);
        check("rst_bubble", {31'd0, bubble}, 32'd1);
        check("rst_pc_out", pc_out, 32'h0);
    endtask

    // one clock: apply inputs at the falling edge, advance model, check after the rising edge
    task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                        input logic h, input logic rdy);
        stall = s; redirect = r; redirect_pc = rpc; hlt = h; imem_bus.imem_ready = rdy;
        if (m_halt) begin
            m_bcnt++;
        end else if (r) begin
            m_pc = rpc; m_instr = NOP; m_bub = 1; m_bcnt++;
        end else if (h) begin
            m_halt = 1; m_instr = NOP; m_bub = 1; m_bcnt++;
        end else if (s) begin
            m_pc = m_pc;
        end else if (rdy) begin
            m_instr = mem_word(m_pc); m_bub = 0; m_pc_out = m_pc; m_pc = m_pc + 4; m_fcnt++;
        end else begin
            m_instr = NOP; m_bub = 1; m_bcnt++;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("fetch4_instr", instruction, 32'h00A0_0093);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("stall_addr", imem_bus.imem_addr, 32'h8);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("resume_pc_out", pc_out, 32'h8);
        step(0, 0, 0, 0, 1);
        step(1, 1, 32'h100, 0, 1);
        check("redir_addr", imem_bus.imem_addr, 32'h100);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'hFFFF_FFFE, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'hFFFF_FFFC, 0, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_addr", imem_bus.imem_addr, 32'h0);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h200, 0, 1);
        step(1, 1, 32'h300, 1, 0);
        step(0, 0, 0, 0, 1);
        check("halt_req", {31'd0, imem_bus.imem_req}, 32'd0);
        do_reset();
        check("post_halt_req", {31'd0, imem_bus.imem_req}, 32'd1);

        repeat (5) step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetch5", fetch_cnt, 32'd5);
        check("perf_bubble2", bubble_cnt, 32'd2);
`endif

        for (int i = 0; i < 400; i++) begin
            if (m_halt && ($urandom % 6 == 0)) begin
                do_reset();
            end else begin
                step(($urandom % 5) == 0, ($urandom % 10) == 0, $urandom,
                     ($urandom % 60) == 0, ($urandom % 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the pipeline; produces the 32-bit instruction word and bubble flag consumed by the instruction decoder.
- Owns the PC and issues requests to instruction memory with a ready handshake.
- Inserts bubbles on memory wait and on control-flow redirect; holds its output under decode stall.
- Stops fetching permanently once the decoder raises halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven on instruction while bubble=1 (addi x0,x0,0).
- PC_STEP, 4, PC increment per accepted instruction.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; always equals current PC.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory response valid for imem_addr this cycle.
- stall  in  1  hazard unit: hold the decode-stage instruction.
- redirect  in  1  taken branch/jal/jalr resolved; flush and reload PC.
- redirect_pc  in  32  new PC; sampled when redirect=1.
- hlt  in  1  decoder halt (already gated by ~bubble).
- instruction  out  32  registered instruction to decoder.
- bubble  out  1  registered; 1 = instruction is not architectural.
- pc_out  out  32  registered PC of the word on instruction (for jal/jalr link, branch target).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, instruction=NOP_INSTR, bubble=1, pc_out=RESET_PC, state=RUN. imem_req goes low during reset; it first asserts in the first cycle after release.
- States:
  - RUN: imem_req=1, imem_addr=pc.
  - HALT: imem_req=0.
  - imem_addr is a combinational copy of pc in both states.
- Per-cycle update in RUN, first matching rule wins:
  - redirect=1: pc<=redirect_pc, instruction<=NOP_INSTR, bubble<=1. Overrides stall, hlt and imem_ready; any concurrent memory response is discarded.
  - hlt=1: state<=HALT, instruction<=NOP_INSTR, bubble<=1, pc holds.
  - stall=1: instruction, bubble, pc_out and pc all hold; memory response ignored. Request stays asserted at the same address.
  - imem_ready=1: instruction<=imem_rdata, bubble<=0, pc_out<=pc, pc<=pc+PC_STEP (mod 2^32, wraps 32'hFFFF_FFFC to 0).
  - otherwise (memory wait): instruction<=NOP_INSTR, bubble<=1, pc holds.
- HALT: outputs frozen at NOP_INSTR/bubble=1 and inputs ignored, including redirect. Only rst_n exits HALT.
- Latency: word accepted at edge N appears on instruction after edge N. After reset or redirect, the first valid word appears no earlier than 2 cycles later.
- Request address is stable from assertion until imem_ready or redirect; memory may depend on this.
- redirect_pc is not alignment-checked; low bits pass through unchanged.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each accepted word (the imem_ready rule).
  - bubble_cnt increments on each edge that loads bubble<=1, including in HALT.
  - Both counters wrap silently and hold during stall.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then imem_ready=1 every cycle, memory returns addr-based words. imem_addr sequence must be 0,4,8,C; instruction must follow one cycle behind with bubble=0 and pc_out=0,4,8.
- imem_ready=0 for 3 cycles at pc=8. imem_addr must hold 8, bubble=1 and instruction=32'h13 for 3 cycles, then resume with pc_out=8.
- stall=1 for 2 cycles while instruction=32'h00A0_0093 (pc_out=4). Outputs must hold exactly and imem_addr must stay 8.
- redirect=1, redirect_pc=32'h0000_0100, driven together with stall=1 and imem_ready=1. Next cycle: bubble=1, imem_addr=0x100; then instruction from 0x100 with pc_out=0x100.
- Halt: hlt=1 for one cycle. imem_req must go 0 and bubble stay 1 indefinitely, with a later redirect ignored. Pulsing rst_n=0 must restore imem_addr=0 and imem_req=1.
- With IFETCH_PERF_CNT_EN: 5 accepted words plus 2 wait cycles must give fetch_cnt=5, bubble_cnt=2 (no reset-time bubble counted).
